// File: rtl/bus_arbiter4.sv
// Round-robin 4:1 arbiter that grants one requester and drives the shared mux select.
// Latency: gnt/sel/bus_valid register one cycle after req is sampled; handovers are bubble-free.
// Backpressure: none; requests are level-sensitive, and an owner is preempted after MAX_HOLD contested cycles.
module bus_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       bus_valid,
  output logic       preempted
);

  typedef enum logic {IDLE, GRANT} state_e;

  // hold_cnt value at which a contested owner must give up the bus
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       preempted_q, preempted_d;

  logic [3:0] others;
  logic [3:0] cand;
  logic       new_grant;
  logic [1:0] win;

  // First set bit of cand, scanning start, start+1, start+2, start+3 (mod 4)
  function automatic logic [1:0] rr_pick(input logic [3:0] c, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (c[idx]) rr_pick = idx;
    end
  endfunction

  // State register: all flops, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= 8'd0;
      gnt_q       <= 4'b0000;
      sel_q       <= 2'd0;
      preempted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      preempted_q <= preempted_d;
    end
  end

  // Next-state: release beats preempt beats keep; any new grant reloads owner/ptr/sel
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    preempted_d = 1'b0;
    others      = req & ~(4'b0001 << owner_q);
    cand        = req;
    new_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          cand      = req;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          if (|others) begin
            cand      = others;
            new_grant = 1'b1;
          end else begin
            state_d    = IDLE;
            gnt_d      = 4'b0000;
            hold_cnt_d = 8'd0;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && (|others)) begin
          cand        = others;
          new_grant   = 1'b1;
          preempted_d = 1'b1;
        end else if (|others) begin
          // Count only contested cycles, saturating
          if (hold_cnt_q != 8'hFF) hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          hold_cnt_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    win = rr_pick(cand, ptr_q);
    if (new_grant) begin
      state_d    = GRANT;
      owner_d    = win;
      ptr_d      = win + 2'd1;
      sel_d      = win;
      hold_cnt_d = 8'd0;
      gnt_d      = 4'b0001 << win;
    end
  end

  // Outputs come straight from registers so the mux select is glitch-free
  always_comb begin
    gnt       = gnt_q;
    sel       = sel_q;
    bus_valid = |gnt_q;
    preempted = preempted_q;
  end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboard bench for bus_arbiter4: three instances (MAX_HOLD 3, 0, 2) share req/rst.
// A reference model predicts each instance's outputs and a monitor compares them every cycle.
module tb_bus_arbiter4;

  localparam int NI = 3;
  localparam int MH [NI] = '{3, 0, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt_w [NI];
  logic [1:0] sel_w [NI];
  logic       bv_w  [NI];
  logic       pre_w [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bus_arbiter4 #(.MAX_HOLD(MH[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt_w[g]),
      .sel       (sel_w[g]),
      .bus_valid (bv_w[g]),
      .preempted (pre_w[g])
    );
  end

  typedef struct packed {
    logic [NI-1:0][3:0] gnt;
    logic [NI-1:0][1:0] sel;
    logic [NI-1:0]      pre;
  } exp_t;

  exp_t exp_q [$];
  int checks = 0;
  int errors = 0;

  // Reference model state, one entry per instance
  int m_busy  [NI];
  int m_owner [NI];
  int m_ptr   [NI];
  int m_hold  [NI];
  int m_sel   [NI];
  int m_pre   [NI];
  int m_age   [NI];

  function automatic int rr_first(input int cand, input int start);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (start + k) % 4;
      if (((cand >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic rs);
    int rv;
    rv = int'(r);
    for (int i = 0; i < NI; i++) begin
      if (rs) begin
        m_busy[i] = 0; m_owner[i] = 0; m_ptr[i] = 0; m_hold[i] = 0;
        m_sel[i] = 0; m_pre[i] = 0; m_age[i] = 0;
      end else begin
        int others;
        int win;
        win = -1;
        m_pre[i] = 0;
        others = (m_busy[i] != 0) ? (rv & ~(1 << m_owner[i])) : 0;
        if (m_busy[i] == 0) begin
          if (rv != 0) win = rr_first(rv, m_ptr[i]);
        end else if (((rv >> m_owner[i]) & 1) == 0) begin
          if (others != 0) win = rr_first(others, m_ptr[i]);
          else begin
            m_busy[i] = 0;
            m_hold[i] = 0;
          end
        end else if (MH[i] != 0 && m_hold[i] == MH[i] - 1 && others != 0) begin
          win = rr_first(others, m_ptr[i]);
          m_pre[i] = 1;
        end else begin
          if (others != 0) m_hold[i] = (m_hold[i] < 255) ? m_hold[i] + 1 : 255;
          else m_hold[i] = 0;
          m_age[i]++;
        end
        if (win >= 0) begin
          m_busy[i]  = 1;
          m_owner[i] = win;
          m_ptr[i]   = (win + 1) % 4;
          m_sel[i]   = win;
          m_hold[i]  = 0;
          m_age[i]   = 1;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge
  task automatic drive(input logic [3:0] r, input logic rs);
    exp_t e;
    @(negedge clk);
    req = r;
    rst = rs;
    model_step(r, rs);
    for (int i = 0; i < NI; i++) begin
      e.gnt[i] = (m_busy[i] != 0) ? 4'(1 << m_owner[i]) : 4'b0000;
      e.sel[i] = 2'(m_sel[i]);
      e.pre[i] = (m_pre[i] != 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs after each edge against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("gnt[mh=%0d]", MH[i]), int'(gnt_w[i]), int'(e.gnt[i]));
          chk($sformatf("sel[mh=%0d]", MH[i]), int'(sel_w[i]), int'(e.sel[i]));
          chk($sformatf("bus_valid[mh=%0d]", MH[i]), int'(bv_w[i]), int'(e.gnt[i] != 4'b0000));
          chk($sformatf("preempted[mh=%0d]", MH[i]), int'(pre_w[i]), int'(e.pre[i]));
          chk($sformatf("onehot[mh=%0d]", MH[i]), int'($countones(gnt_w[i]) <= 1), 1);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0] r;

    // Single requester
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);
    for (int c = 0; c < 5; c++) drive(4'b0100, 1'b0);
    for (int c = 0; c < 3; c++) drive(4'b0000, 1'b0);

    // Round-robin fairness: owner drops its bit for one cycle after two granted cycles
    drive(4'b0000, 1'b1);
    for (int c = 0; c < 16; c++) begin
      r = 4'b1111;
      if (m_busy[1] != 0 && m_age[1] >= 2) r[m_owner[1]] = 1'b0;
      drive(r, 1'b0);
    end

    // Preemption on / off with two constant competitors
    drive(4'b0000, 1'b1);
    for (int c = 0; c < 50; c++) drive(4'b0011, 1'b0);
    drive(4'b0000, 1'b0);

    // Release coincides with the preempt condition
    drive(4'b0000, 1'b1);
    drive(4'b1001, 1'b0);
    drive(4'b1001, 1'b0);
    drive(4'b1000, 1'b0);
    drive(4'b1000, 1'b0);

    // Reset mid-grant
    drive(4'b0000, 1'b1);
    drive(4'b0010, 1'b0);
    drive(4'b0010, 1'b0);
    drive(4'b1111, 1'b1);
    drive(4'b1111, 1'b0);
    drive(4'b1111, 1'b0);

    // Random traffic with sticky requests and occasional reset
    r = 4'b0000;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      drive(r, ($urandom_range(0, 199) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
# bus_arbiter4

Round-robin arbiter and select controller for the processor's shared 8-bit 4:1 data mux. Four requesters (program fetch, tape read, I/O input, debug port) compete for the mux output. The block grants one requester at a time and drives the mux `sel` directly. A grant is held while the owner keeps requesting, subject to an optional maximum hold time when others are waiting.

## Interface

Parameters:

- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another requester is pending. Range 0..255; 0 disables preemption.

Ports:

- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `req`, input, 4: request per requester; bit i is requester i.
- `gnt`, output, 4: one-hot grant, or all zero; registered.
- `sel`, output, 2: mux select; equals the index of the granted requester; registered.
- `bus_valid`, output, 1: high exactly when `gnt` is non-zero.
- `preempted`, output, 1: one-cycle pulse when a grant is removed by the hold limit.

## Operation

- State: `IDLE` or `GRANT`, plus `owner[1:0]`, `ptr[1:0]` (highest-priority index) and `hold_cnt[7:0]`.
- Reset values: `gnt` = 0000, `sel` = 00, `bus_valid` = 0, `preempted` = 0, `ptr` = 0, `hold_cnt` = 0, state `IDLE`.
- Round-robin pick: the first set bit of the candidate set, scanning `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 mod 4. On every new grant to index k:
  - `ptr` ← k+1 mod 4
  - `owner` ← k
  - `sel` ← k
  - `hold_cnt` ← 0
- `IDLE`:
  - If `req` ≠ 0, pick from `req` and go to `GRANT`.
  - Otherwise stay; `sel` holds its last value.
- `GRANT`, evaluated in this priority order:
  1. `req[owner]` = 0 (release): if other bits are set, pick from `req` with owner masked and stay in `GRANT` (zero-bubble handover). Otherwise go to `IDLE` with `gnt` = 0.
  2. `MAX_HOLD` ≠ 0, `hold_cnt` = `MAX_HOLD`−1, and another `req` bit is set (preempt): pick from `req` with owner masked and pulse `preempted` for 1 cycle.
  3. Otherwise keep the grant; `hold_cnt` increments, saturating at 255.
- `hold_cnt` counts only while another requester is pending. It resets to 0 in any cycle where the owner is the sole requester.
- `gnt` is always one-hot or zero. It never has two bits set, including during a handover.
- Requests are not latched. Dropping `req[i]` before it is granted withdraws the request.

## Timing

- Grant latency: `gnt`, `sel` and `bus_valid` rise 1 cycle after the edge where `req` is first sampled high from `IDLE`.
- Release latency: `gnt[owner]` falls 1 cycle after `req[owner]` is sampled low. A successor's grant appears in that same cycle.
- Preemption: with a competitor pending continuously, the owner holds the grant for exactly `MAX_HOLD` cycles. The new grant and `preempted` appear together on the next edge.
- A preempted owner keeping `req` high re-enters arbitration. With rotating priority it waits at most 3 other grants.
- Simultaneous release and preempt condition in the same cycle: release rules, and `preempted` stays 0.
- Reset mid-grant: the cycle after `rst` is sampled high, all outputs are at their reset values and `ptr` = 0, regardless of `req`.
- `sel` changes only on a new grant; it is stable for the whole grant, as the mux requires.

## Test plan

- Single requester: reset, then `req` = 0100 for 5 cycles, then 0000. Required: `gnt` = 0100, `sel` = 10 and `bus_valid` = 1 from cycle 1 through cycle 5. `gnt` = 0000 one cycle after the drop; `sel` stays 10.
- Round-robin fairness: `req` = 1111 with each owner dropping its bit for 1 cycle after 2 cycles of grant. Required: grant order 0, 1, 2, 3, 0, with each handover occurring with no idle cycle.
- Preemption with `MAX_HOLD` = 3: `req` = 0011 held constant. Required:
  - `gnt` = 0001 for exactly 3 cycles, then 0010 for 3 cycles, then 0001.
  - `preempted` = 1 in the first cycle of each new grant.
- Preemption disabled with `MAX_HOLD` = 0: `req` = 0011 for 50 cycles. Required: `gnt` = 0001 throughout and `preempted` never 1.
- Release beats preempt with `MAX_HOLD` = 2: owner 0 drops `req[0]` on the same cycle `hold_cnt` hits 1 while `req[3]` = 1. Required: `gnt` = 1000 next cycle and `preempted` = 0.
- Reset mid-grant: while `gnt` = 0010, assert `rst` for 1 cycle with `req` = 1111. Required:
  - Next cycle `gnt` = 0000, `sel` = 00, `bus_valid` = 0.
  - After `rst` deasserts, the first grant is 0001.
